// File: rtl/ascon_perm_ctrl.sv
// Iterative sequencer for the ASCON permutation p^a: owns the 320-bit state and
// steps an external single-round datapath once per clock under a start/done handshake.
module ascon_perm_ctrl #(
    parameter int unsigned MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   rounds,
    input  logic [319:0] state_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [319:0] state_out,
    output logic [3:0]   rnd_a,
    output logic [3:0]   rnd_i,
    output logic [319:0] rnd_x,
    input  logic [319:0] rnd_y
);

    localparam int unsigned STATE_W = 320;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

    fsm_t               fsm;
    logic [STATE_W-1:0] state_q;

    // The datapath always sees the live state; the result is read from the same register.
    assign rnd_x     = state_q;
    assign state_out = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            state_q <= '0;
            rnd_a   <= '0;
            rnd_i   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start) begin
                        if (rounds == 4'd0) begin
                            // Zero rounds: the identity permutation, answered immediately.
                            state_q <= state_in;
                            done    <= 1'b1;
                        end else if (32'(rounds) > MAX_ROUNDS) begin
                            err <= 1'b1;
                        end else begin
                            state_q <= state_in;
                            rnd_a   <= rounds;
                            rnd_i   <= 4'd0;
                            busy    <= 1'b1;
                            fsm     <= RUN;
                        end
                    end
                end
                RUN: begin
                    state_q <= rnd_y;
                    if (rnd_i == 4'(rnd_a - 4'd1)) begin
                        rnd_i <= 4'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        fsm   <= IDLE;
                    end else begin
                        rnd_i <= 4'(rnd_i + 4'd1);
                    end
                end
                default: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Self-checking bench for ascon_perm_ctrl: selectable stub (+1) or real ASCON round
// datapath, a whole-run behavioural model, and directed scenarios.
module tb_ascon_perm_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   rounds;
    logic [319:0] state_in;
    logic         busy, done, err;
    logic [319:0] state_out;
    logic [3:0]   rnd_a, rnd_i;
    logic [319:0] rnd_x, rnd_y;

    bit           real_dp = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    ascon_perm_ctrl #(.MAX_ROUNDS(12)) dut (
        .clk(clk), .rst(rst), .start(start), .rounds(rounds), .state_in(state_in),
        .busy(busy), .done(done), .err(err), .state_out(state_out),
        .rnd_a(rnd_a), .rnd_i(rnd_i), .rnd_x(rnd_x), .rnd_y(rnd_y)
    );

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [7:0] rc(input int idx);
        return 8'(((15 - idx) << 4) | idx);
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256]; x1 = s[255:192]; x2 = s[191:128]; x3 = s[127:64]; x4 = s[63:0];
        x2 ^= {56'd0, c};
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 ^= ror(x0, 19) ^ ror(x0, 28);
        x1 ^= ror(x1, 61) ^ ror(x1, 39);
        x2 ^= ror(x2, 1)  ^ ror(x2, 6);
        x3 ^= ror(x3, 10) ^ ror(x3, 17);
        x4 ^= ror(x4, 7)  ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Whole permutation p^a: round indices run 12-a .. 11.
    function automatic logic [319:0] perm(input logic [319:0] s, input int a, input bit use_real);
        logic [319:0] v;
        v = s;
        if (!use_real) return v + 320'(a);
        for (int r = 12 - a; r < 12; r++) v = ascon_round(v, rc(r));
        return v;
    endfunction

    // External round datapath driven from the controller outputs.
    logic [3:0] dp_idx;
    logic [7:0] dp_c;
    always_comb begin
        dp_idx = 4'(4'd12 - rnd_a + rnd_i);
        dp_c   = {4'(4'd15 - dp_idx), dp_idx};
        rnd_y  = real_dp ? ascon_round(rnd_x, dp_c) : rnd_x + 320'd1;
    end

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks a run as "rounds left" and its final result.
    bit           m_busy = 0, m_done = 0, m_err = 0;
    int           m_left = 0;
    logic [3:0]   m_a = '0;
    logic [319:0] m_result = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_left = 0; m_a = '0; m_result = '0;
        end else begin
            m_done = 0;
            m_err  = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (start) begin
                if (rounds == 4'd0) begin
                    m_result = state_in;
                    m_done   = 1;
                end else if (int'(rounds) > 12) begin
                    m_err = 1;
                end else begin
                    m_busy   = 1;
                    m_left   = int'(rounds);
                    m_a      = rounds;
                    m_result = perm(state_in, int'(rounds), real_dp);
                end
            end
        end
    end

    int         busy_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [7:0] cq[$];

    // Per-cycle compare against the model, plus event counters for directed checks.
    always @(negedge clk) begin
        check("busy", 320'(busy), 320'(m_busy));
        check("done", 320'(done), 320'(m_done));
        check("err", 320'(err), 320'(m_err));
        check("rnd_a", 320'(rnd_a), 320'(m_a));
        check("rnd_i", 320'(rnd_i), m_busy ? 320'(int'(m_a) - m_left) : 320'd0);
        if (!m_busy) check("state_out", state_out, m_result);
        if (busy) begin
            busy_cnt++;
            cq.push_back(dp_c);
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic clear_counts();
        busy_cnt = 0; done_cnt = 0; err_cnt = 0;
        cq.delete();
    endtask

    task automatic do_start(input logic [3:0] a, input logic [319:0] s);
        start = 1'b1; rounds = a; state_in = s;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk); #2;
            if (done) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_done: no done within 40 cycles at %0t", $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [319:0] saved;

    initial begin
        rst = 1'b1; start = 1'b0; rounds = '0; state_in = '0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_busy", 320'(busy), 320'd0);
        check("reset_state", state_out, 320'd0);
        check("reset_rnd", 320'({rnd_a, rnd_i}), 320'd0);
        rst = 1'b0;
        idle(1);

        // Twelve stub rounds from zero.
        clear_counts();
        do_start(4'd12, 320'd0);
        wait_done();
        check("p12_stub_result", state_out, 320'd12);
        check("p12_busy_cycles", 320'(busy_cnt), 320'd12);
        idle(2);
        check("p12_done_pulses", 320'(done_cnt), 320'd1);

        // Round-constant sequence for a=6 and first constant for a=8.
        clear_counts();
        do_start(4'd6, 320'd7);
        wait_done();
        check("a6_const_count", 320'(cq.size()), 320'd6);
        check("a6_first_const", 320'(cq[0]), 320'h96);
        check("a6_last_const", 320'(cq[5]), 320'h4B);
        for (int j = 0; j < 6 && j < cq.size(); j++)
            check("a6_index_seq", 320'(cq[j][3:0]), 320'(6 + j));
        idle(1);
        clear_counts();
        do_start(4'd8, 320'd0);
        wait_done();
        check("a8_first_const", 320'(cq[0]), 320'hB4);
        idle(1);

        // Back-to-back: next start issued in the done cycle.
        clear_counts();
        do_start(4'd6, 320'd0);
        wait_done();
        do_start(4'd8, 320'd5);
        check("b2b_accepted", 320'(busy), 320'd1);
        wait_done();
        check("b2b_result", state_out, 320'd13);
        idle(2);
        check("b2b_done_pulses", 320'(done_cnt), 320'd2);

        // start held through a run is ignored.
        clear_counts();
        start = 1'b1; rounds = 4'd3; state_in = 320'd40;
        @(posedge clk); #2;
        rounds = 4'd9;
        repeat (3) @(posedge clk);
        #2;
        start = 1'b0;
        check("hold_done_now", 320'(done), 320'd1);
        check("hold_rnd_a", 320'(rnd_a), 320'd3);
        check("hold_result", state_out, 320'd43);
        idle(3);
        check("hold_done_pulses", 320'(done_cnt), 320'd1);

        // Zero rounds, then an over-range request.
        clear_counts();
        do_start(4'd0, {64'hDEADBEEF, 256'h1234});
        check("a0_done", 320'(done), 320'd1);
        check("a0_result", state_out, {64'hDEADBEEF, 256'h1234});
        idle(2);
        check("a0_busy_cycles", 320'(busy_cnt), 320'd0);
        clear_counts();
        saved = state_out;
        do_start(4'd13, 320'd99);
        check("a13_err", 320'(err), 320'd1);
        idle(2);
        check("a13_err_pulses", 320'(err_cnt), 320'd1);
        check("a13_no_done", 320'(done_cnt), 320'd0);
        check("a13_state_kept", state_out, saved);

        // Reset during round 5 of a 12-round run, then a fresh run.
        clear_counts();
        do_start(4'd12, 320'd0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("rst_busy", 320'(busy), 320'd0);
        check("rst_done", 320'(done), 320'd0);
        check("rst_state", state_out, 320'd0);
        check("rst_rnd_i", 320'(rnd_i), 320'd0);
        idle(2);
        check("rst_no_done", 320'(done_cnt), 320'd0);
        do_start(4'd4, 320'd100);
        wait_done();
        check("post_rst_result", state_out, 320'd104);
        idle(1);

        // Real ASCON round datapath: ASCON-128 initialization, p^12.
        real_dp = 1'b1;
        saved = {64'h80400c0600000000, 256'd0};
        do_start(4'd12, saved);
        wait_done();
        check("ascon_p12", state_out, perm(saved, 12, 1'b1));
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
Iterative sequencer for the ASCON permutation p^a. It owns the 320-bit state register and steps the external single-round datapath (add_constants → substitution → linear layer) one round per clock. It drives the round count a and the round index i that add_constants uses to form its constant index I = 12 − a + i. It serves both initialization/finalization (a=12) and data processing (a=6 or a=8) under a start/done handshake.

Parameters:
MAX_ROUNDS, 12, largest legal round count. A request with a > MAX_ROUNDS is rejected.

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a permutation; sampled only in IDLE
rounds  in  4  requested round count a, latched on accepted start
state_in  in  320  initial state {x0,x1,x2,x3,x4}, x0 = bits 319:256, latched on accepted start
busy  out  1  high while rounds are executing
done  out  1  one-cycle pulse: state_out holds the completed result
err  out  1  one-cycle pulse: start rejected because rounds > MAX_ROUNDS
state_out  out  320  state register; valid when done pulses, held until next accepted start
rnd_a  out  4  latched a, to add_constants input a
rnd_i  out  4  current round index i, to add_constants input i
rnd_x  out  320  round datapath input; always equals the state register
rnd_y  in  320  round datapath output, combinational from rnd_x/rnd_a/rnd_i

Behaviour:
- Reset: FSM = IDLE; state register = 0; rnd_a = 0; rnd_i = 0; busy = 0; done = 0; err = 0. Reset overrides everything, including mid-run. A run in progress is abandoned with no done pulse.
- States: IDLE, RUN.
- IDLE, start=1, 1 ≤ rounds ≤ MAX_ROUNDS:
  - state register ← state_in; rnd_a ← rounds; rnd_i ← 0; → RUN; busy=1 from the next cycle.
- IDLE, start=1, rounds = 0:
  - state register ← state_in; stay IDLE; done pulses next cycle; state_out = state_in.
- IDLE, start=1, rounds > MAX_ROUNDS:
  - no register change except err=1 for one cycle; stay IDLE.
- RUN, each edge:
  - state register ← rnd_y; rnd_i ← rnd_i + 1.
  - If rnd_i == rnd_a − 1 (last round): rnd_i ← 0; → IDLE; busy ← 0; done ← 1 for exactly one cycle.
- Latency: start accepted at edge k; rounds execute at edges k+1 … k+a; done is high in the cycle after edge k+a.
- start during RUN is ignored. No queueing and no err.
- Back-to-back: start may be asserted in the done cycle (FSM already IDLE) and is accepted. state_out then changes at that edge.
- rnd_i ranges 0 … a−1 and never wraps past a−1. rnd_a is stable for a whole run.
- Round constant seen by the datapath:
  - c = ((15 − I) << 4) | I, with I = 12 − rnd_a + rnd_i, 4-bit arithmetic.
  - The controller guarantees 12 − a + i ∈ [12−a, 11], so I never exceeds 11.
- done and err are never high in the same cycle. busy and done are never high in the same cycle.
- state_out is registered only; no combinational path from any input to any output.

Test Plan:
- Stub datapath rnd_y = rnd_x + 1. rounds=12, state_in=0, pulse start → busy high 12 cycles; done one cycle after the 12th round edge; state_out = 320'd12.
- rounds=6, monitor add_constants index → I sequence 6,7,8,9,10,11. First constant 0x96, last 0x4B. rounds=8 → first constant 0xB4.
- rounds=6 then start asserted in the done cycle with rounds=8, state_in=5 (stub +1) → second run accepted with no gap; state_out = 13; exactly two done pulses.
- start held high during RUN with rounds=3 → ignored; single done; rnd_a stays at the original value.
- rounds=0 → done after 1 cycle, state_out = state_in, busy never high. rounds=13 → err pulse, no done, state unchanged.
- rst asserted at round 5 of a 12-round run → next cycle busy=0, done=0, state_out=0, rnd_i=0. A fresh start afterwards completes normally.
- Real ASCON round datapath, rounds=12, state_in = ASCON-128 init (IV 0x80400c0600000000, K=0, N=0) → state_out matches the reference-model p^12 output bit-exact.
